phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter FRAME_LEN, default 21; the count sequence length, legal counts are 0..FRAME_LEN-1.
REQ-002 Parameter A_END, default 10; the last count of window A.
REQ-003 Parameter B_END, default 18; the last count of window B. Window C spans B_END+1..FRAME_LEN-1.
REQ-004 Parameter LOCK_CNT, default 4; the number of consecutive valid count steps required to lock.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 count  input  6  free-running count from the upstream clock/count generator.
REQ-008 en_a / en_b / en_c  output  1 each  one-hot window enables, registered.
REQ-009 frame_start  output  1  one-cycle strobe at count 0 while locked.
REQ-010 locked  output  1  high while the sequencer is in LOCKED.
REQ-011 sync_err  output  1  one-cycle strobe on loss of lock.
REQ-012 frame_cnt  output  8  number of frames seen while locked, wraps 255 to 0.
REQ-013 err_cnt  output  4  number of sync_err events, saturates at 15.

Function
REQ-014 The block SHALL register count into prev each cycle; prev resets to 0.
REQ-015 Step validity: a step SHALL be valid iff count < FRAME_LEN and either count == prev+1, or prev == FRAME_LEN-1 with count == 0.
REQ-016 The FSM SHALL have three states: UNLOCKED, ACQUIRE and LOCKED.
REQ-017 UNLOCKED SHALL go to ACQUIRE when count == 0 and SHALL clear good_cnt to 0.
REQ-018 In ACQUIRE, a valid step SHALL increment good_cnt.
REQ-019 In ACQUIRE, an invalid step SHALL return the FSM to UNLOCKED with no sync_err.
REQ-020 In ACQUIRE, when good_cnt reaches LOCK_CNT the FSM SHALL go to LOCKED on that same edge.
REQ-021 In LOCKED, an invalid step SHALL go to UNLOCKED, pulse sync_err for one cycle and increment err_cnt (saturating).
REQ-022 In LOCKED with a valid step, the outputs on the next edge SHALL be:
  - en_a = 1 when count <= A_END;
  - en_b = 1 when A_END < count <= B_END;
  - en_c = 1 when count > B_END;
  - frame_start = 1 when count == 0.
REQ-023 Output latency SHALL be exactly 1 cycle from count to en_*/frame_start.
REQ-024 While not in LOCKED, en_a, en_b, en_c and frame_start SHALL be 0.
REQ-025 The cycle that detects an invalid step while LOCKED SHALL drive all en_* to 0.
REQ-026 locked SHALL be registered and SHALL reflect the state after the edge.
REQ-027 frame_cnt SHALL increment on the same edge that asserts frame_start, wrapping 255 to 0.
REQ-028 frame_cnt SHALL hold its value while unlocked.
REQ-029 Precedence: an invalid step with count == 0 while LOCKED SHALL give sync_err=1 and frame_start=0, and frame_cnt SHALL NOT increment.
REQ-030 count values >= FRAME_LEN SHALL be invalid in every state and SHALL never produce an en_* output.
REQ-031 The en_* outputs SHALL be mutually exclusive in every cycle.
REQ-032 Parameter legality: 0 <= A_END < B_END < FRAME_LEN-1, FRAME_LEN <= 64, and 1 <= LOCK_CNT <= 15; the implementation SHALL flag violations at elaboration.

Reset
REQ-033 On a rising clk edge with rst_n == 0:
  - the state SHALL be UNLOCKED;
  - prev, good_cnt, frame_cnt and err_cnt SHALL be 0;
  - all 1-bit outputs SHALL be 0.
REQ-034 Reset asserted mid-frame while LOCKED SHALL take effect on that edge with no sync_err pulse.
REQ-035 After reset is released, the block SHALL relock only via UNLOCKED and ACQUIRE.

Verification
REQ-036 Lock-up: release reset, drive count 0,1,2,… → locked rises on the edge sampling count 4; the first frame_start appears at the next count 0; frame_cnt = 1.
REQ-037 Windows: locked, one full frame 0..20 → en_a high for 11 cycles, en_b high for 8, en_c high for 2; exactly one en_* high per cycle; each output lags count by 1 cycle.
REQ-038 Glitch: locked, count sequence 5,6,9 → sync_err pulses once; locked = 0 the next cycle; err_cnt = 1; en_* = 0 until relock.
REQ-039 Out-of-range: drive count = 25 while locked → sync_err is asserted and no en_* is asserted; count = 25 while in UNLOCKED → no state change.
REQ-040 Saturation/wrap: 20 forced glitches → err_cnt = 15; 256 locked frames → frame_cnt wraps to 0.
REQ-041 Reset mid-operation: rst_n = 0 at count 13 while locked → all outputs 0 on that edge with no sync_err; relock requires a new count 0 plus 4 valid steps.

Source files
------------

// File: rtl/phase_sequencer.sv
// Frame-phase sequencer: locks onto a free-running count, then decodes the count into
// one-hot window enables A/B/C plus a frame strobe, with lock-loss and frame statistics.
module phase_sequencer #(
  parameter int unsigned FRAME_LEN = 21,
  parameter int unsigned A_END     = 10,
  parameter int unsigned B_END     = 18,
  parameter int unsigned LOCK_CNT  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] count,
  output logic       en_a,
  output logic       en_b,
  output logic       en_c,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err,
  output logic [7:0] frame_cnt,
  output logic [3:0] err_cnt
);

  if (!(FRAME_LEN >= 3 && FRAME_LEN <= 64 && A_END < B_END && B_END < FRAME_LEN - 1 &&
        LOCK_CNT >= 1 && LOCK_CNT <= 15)) begin : g_param_check
    $error("phase_sequencer: illegal parameter combination");
  end

  localparam logic [6:0] LastCnt = 7'(FRAME_LEN - 1);
  localparam logic [6:0] AEnd    = 7'(A_END);
  localparam logic [6:0] BEnd    = 7'(B_END);
  localparam logic [3:0] LockCnt = 4'(LOCK_CNT);

  typedef enum logic [1:0] {StUnlocked, StAcquire, StLocked} state_e;

  state_e     state_q, state_d;
  logic [5:0] prev_q;
  logic [3:0] good_q, good_d;
  logic [7:0] frame_cnt_d;
  logic [3:0] err_cnt_d;
  logic       en_a_d, en_b_d, en_c_d, frame_start_d, sync_err_d;

  logic [6:0] count_w;
  logic [6:0] prev_w;
  logic       step_ok;

  // Widen to 7 bits so prev+1 cannot alias and out-of-range counts compare correctly.
  assign count_w = {1'b0, count};
  assign prev_w  = {1'b0, prev_q};
  assign step_ok = (count_w <= LastCnt) &&
                   ((count_w == prev_w + 7'd1) || (prev_w == LastCnt && count_w == 7'd0));

  always_comb begin
    state_d       = state_q;
    good_d        = good_q;
    frame_cnt_d   = frame_cnt;
    err_cnt_d     = err_cnt;
    en_a_d        = 1'b0;
    en_b_d        = 1'b0;
    en_c_d        = 1'b0;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;
    unique case (state_q)
      StUnlocked: begin
        if (count_w == 7'd0) begin
          state_d = StAcquire;
          good_d  = '0;
        end
      end
      StAcquire: begin
        if (step_ok) begin
          good_d = good_q + 4'd1;
          if (good_d == LockCnt) state_d = StLocked;
        end else begin
          state_d = StUnlocked;
        end
      end
      StLocked: begin
        if (step_ok) begin
          en_a_d = (count_w <= AEnd);
          en_b_d = (count_w > AEnd) && (count_w <= BEnd);
          en_c_d = (count_w > BEnd);
          if (count_w == 7'd0) begin
            frame_start_d = 1'b1;
            frame_cnt_d   = frame_cnt + 8'd1;
          end
        end else begin
          // Lock loss wins over a coincident count of 0: no strobe, no frame count.
          state_d    = StUnlocked;
          sync_err_d = 1'b1;
          if (err_cnt != 4'hF) err_cnt_d = err_cnt + 4'd1;
        end
      end
      default: state_d = StUnlocked;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StUnlocked;
      prev_q      <= '0;
      good_q      <= '0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
      en_a        <= 1'b0;
      en_b        <= 1'b0;
      en_c        <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= count;
      good_q      <= good_d;
      frame_cnt   <= frame_cnt_d;
      err_cnt     <= err_cnt_d;
      en_a        <= en_a_d;
      en_b        <= en_b_d;
      en_c        <= en_c_d;
      frame_start <= frame_start_d;
      locked      <= (state_d == StLocked);
      sync_err    <= sync_err_d;
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed lock/window/glitch/reset scenarios
// followed by randomized count streams, all compared against a behavioural model.
module tb_phase_sequencer;

  localparam int FL   = 21;
  localparam int AE   = 10;
  localparam int BE   = 18;
  localparam int LOCK = 4;

  logic       clk;
  logic       rst_n;
  logic [5:0] count;
  logic       en_a, en_b, en_c, frame_start, locked, sync_err;
  logic [7:0] frame_cnt;
  logic [3:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state: mode 0 = hunting for a 0, 1 = counting good steps, 2 = locked.
  int m_mode, m_prev, m_good, m_fc, m_ec;
  bit m_a, m_b, m_c, m_fs, m_lk, m_se;

  phase_sequencer #(
    .FRAME_LEN(FL),
    .A_END    (AE),
    .B_END    (BE),
    .LOCK_CNT (LOCK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .count      (count),
    .en_a       (en_a),
    .en_b       (en_b),
    .en_c       (en_c),
    .frame_start(frame_start),
    .locked     (locked),
    .sync_err   (sync_err),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int c, input bit r);
    bit valid;
    {m_a, m_b, m_c, m_fs, m_se} = '0;
    if (!r) begin
      m_mode = 0; m_prev = 0; m_good = 0; m_fc = 0; m_ec = 0; m_lk = 0;
      return;
    end
    valid = (c < FL) && ((c == m_prev + 1) || (m_prev == FL - 1 && c == 0));
    if (m_mode == 0) begin
      if (c == 0) begin m_mode = 1; m_good = 0; end
    end else if (m_mode == 1) begin
      if (valid) begin
        m_good++;
        if (m_good == LOCK) m_mode = 2;
      end else m_mode = 0;
    end else begin
      if (valid) begin
        m_a = (c <= AE);
        m_b = (c > AE) && (c <= BE);
        m_c = (c > BE);
        if (c == 0) begin m_fs = 1; m_fc = (m_fc + 1) % 256; end
      end else begin
        m_mode = 0; m_se = 1;
        if (m_ec < 15) m_ec++;
      end
    end
    m_lk   = (m_mode == 2);
    m_prev = c;
  endtask

  task automatic step(input int c, input bit r);
    bit onehot_ok;
    @(negedge clk);
    count = 6'(c);
    rst_n = r;
    @(posedge clk);
    #1;
    model_step(c, r);
    check_eq("outs", {26'b0, en_a, en_b, en_c, frame_start, locked, sync_err},
             {26'b0, m_a, m_b, m_c, m_fs, m_lk, m_se});
    check_eq("frame_cnt", {24'b0, frame_cnt}, m_fc);
    check_eq("err_cnt", {28'b0, err_cnt}, m_ec);
    onehot_ok = ($countones({en_a, en_b, en_c}) <= 1);
    check_eq("onehot", {31'b0, onehot_ok}, 32'd1);
  endtask

  task automatic run(input int lo, input int hi);
    for (int c = lo; c <= hi; c++) step(c, 1'b1);
  endtask

  initial begin
    int ca, cb, cc, fc_before, cnt, r;
    rst_n = 1'b0;
    count = '0;
    m_mode = 0; m_prev = 0; m_good = 0; m_fc = 0; m_ec = 0;
    {m_a, m_b, m_c, m_fs, m_lk, m_se} = '0;

    // Reset state
    step(7, 1'b0);
    step(3, 1'b0);
    check_eq("rst_outs", {26'b0, en_a, en_b, en_c, frame_start, locked, sync_err}, 32'd0);
    check_eq("rst_cnts", {20'b0, frame_cnt, err_cnt}, 32'd0);

    // Lock-up
    run(0, 3);
    check_eq("pre_lock", {31'b0, locked}, 32'd0);
    step(4, 1'b1);
    check_eq("lock_at_4", {31'b0, locked}, 32'd1);
    run(5, 20);
    step(0, 1'b1);
    check_eq("first_fs", {31'b0, frame_start}, 32'd1);
    check_eq("first_fc", {24'b0, frame_cnt}, 32'd1);
    run(1, 20);

    // Windows over one full frame
    ca = 0; cb = 0; cc = 0;
    for (int c = 0; c < FL; c++) begin
      step(c, 1'b1);
      ca += int'(en_a); cb += int'(en_b); cc += int'(en_c);
    end
    check_eq("win_a", ca, 32'd11);
    check_eq("win_b", cb, 32'd8);
    check_eq("win_c", cc, 32'd2);

    // Glitch 5,6,9
    run(0, 6);
    step(9, 1'b1);
    check_eq("glitch_se", {31'b0, sync_err}, 32'd1);
    check_eq("glitch_lk", {31'b0, locked}, 32'd0);
    check_eq("glitch_ec", {28'b0, err_cnt}, 32'd1);
    step(10, 1'b1);
    check_eq("glitch_after", {28'b0, en_a, en_b, en_c, sync_err}, 32'd0);

    // Out-of-range while locked, then while unlocked
    run(0, 6);
    step(25, 1'b1);
    check_eq("oor_se", {31'b0, sync_err}, 32'd1);
    check_eq("oor_en", {29'b0, en_a, en_b, en_c}, 32'd0);
    step(25, 1'b1);
    check_eq("oor_unl", {30'b0, locked, sync_err}, 32'd0);

    // Count 0 arriving as an invalid step while locked
    run(0, 6);
    fc_before = int'(frame_cnt);
    step(0, 1'b1);
    check_eq("prec_fs_se", {30'b0, frame_start, sync_err}, 32'd1);
    check_eq("prec_fc", {24'b0, frame_cnt}, fc_before);

    // Reset at count 13 while locked, then relock from scratch
    run(0, 12);
    step(13, 1'b0);
    check_eq("midrst", {26'b0, en_a, en_b, en_c, frame_start, locked, sync_err}, 32'd0);
    run(14, 20);
    run(0, 3);
    check_eq("relock_pre", {31'b0, locked}, 32'd0);
    step(4, 1'b1);
    check_eq("relock", {31'b0, locked}, 32'd1);

    // err_cnt saturation
    for (int g = 0; g < 20; g++) begin
      run(0, 6);
      step(9, 1'b1);
    end
    check_eq("err_sat", {28'b0, err_cnt}, 32'd15);

    // frame_cnt wrap
    step(0, 1'b0);
    run(0, 20);
    for (int f = 1; f <= 256; f++) begin
      run(0, 20);
      if (f == 255 || f == 256) check_eq("fc_wrap", {24'b0, frame_cnt}, f % 256);
    end

    // Randomized streams: mostly sequential with jumps, restarts, out-of-range and resets
    cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        step(cnt, 1'b0);
        continue;
      end else if (r < 6) cnt = int'($urandom_range(0, 63));
      else if (r < 8) cnt = 0;
      else cnt = (cnt >= FL - 1) ? 0 : cnt + 1;
      step(cnt, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
